// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the two-digit display multiplexer
package display_pkg;

  // Scheduler states; the BLANK states are only reachable with DISPLAY_MUX_BLANK_EN defined
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHOW0   = 3'd1,
    BLANK01 = 3'd2,
    SHOW1   = 3'd3,
    BLANK10 = 3'd4
  } mux_state_t;

  // Anode-switch polarity, shared with the switch instantiation
  localparam logic SEL_DIGIT0 = 1'b1;
  localparam logic SEL_DIGIT1 = 1'b0;

  localparam logic [3:0] HEX_IDLE = 4'h0;

endpackage

// File: rtl/display_mux_timer.sv
// rtl/display_mux_timer.sv - saturating interval counter shared by dwell and blank phases
module display_mux_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Count 0..limit and hold there; clear restarts the interval on every state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != limit) begin
      count <= count + WIDTH'(1);
    end
  end

  assign done = (count == limit);

endmodule

// File: rtl/display_mux_ctrl.sv
// rtl/display_mux_ctrl.sv - two-digit seven-segment scheduler; handover blanking under DISPLAY_MUX_BLANK_EN
module display_mux_ctrl
  import display_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  output logic       sel,
  output logic [3:0] hex_out,
  output logic       blank,
  output logic       frame_tick
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] DWELL_LIM = CW'(DWELL_CYCLES - 1);
`ifdef DISPLAY_MUX_BLANK_EN
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES - 1);
`endif

  mux_state_t      state, state_n;
  logic            sel_n;
  logic [3:0]      hex_n;
  logic            blank_n;
  logic            tick_n;
  logic            tmr_clear;
  logic            tmr_done;
  logic [CW-1:0]   tmr_limit;

  // Interval length depends on whether a digit or a blanking gap is being timed
  always_comb begin
    tmr_limit = DWELL_LIM;
`ifdef DISPLAY_MUX_BLANK_EN
    if (state == BLANK01 || state == BLANK10) begin
      tmr_limit = BLANK_LIM;
    end
`endif
  end

  display_mux_timer #(
    .WIDTH (CW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (tmr_clear),
    .limit (tmr_limit),
    .done  (tmr_done)
  );

  // State and output registers; outputs are loaded from the next-state logic
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= SEL_DIGIT0;
      hex_out    <= HEX_IDLE;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      hex_out    <= hex_n;
      blank      <= blank_n;
      frame_tick <= tick_n;
    end
  end

  // Next state and entry actions; digits are sampled only on the edge that loads them
  always_comb begin
    state_n   = state;
    sel_n     = sel;
    hex_n     = hex_out;
    blank_n   = blank;
    tick_n    = 1'b0;
    tmr_clear = 1'b0;

    if (state == IDLE) begin
      tmr_clear = 1'b1;
      if (en) begin
        state_n = SHOW0;
        sel_n   = SEL_DIGIT0;
        hex_n   = digit0;
        blank_n = 1'b0;
      end
    end else if (!en) begin
      // Disable wins over any transition due on the same edge
      state_n   = IDLE;
      sel_n     = SEL_DIGIT0;
      hex_n     = HEX_IDLE;
      blank_n   = 1'b1;
      tmr_clear = 1'b1;
    end else if (tmr_done) begin
      tmr_clear = 1'b1;
      case (state)
        SHOW0: begin
          sel_n = SEL_DIGIT1;
          hex_n = digit1;
`ifdef DISPLAY_MUX_BLANK_EN
          state_n = BLANK01;
          blank_n = 1'b1;
`else
          state_n = SHOW1;
`endif
        end
        SHOW1: begin
          sel_n = SEL_DIGIT0;
          hex_n = digit0;
`ifdef DISPLAY_MUX_BLANK_EN
          state_n = BLANK10;
          blank_n = 1'b1;
`else
          state_n = SHOW0;
          tick_n  = 1'b1;
`endif
        end
`ifdef DISPLAY_MUX_BLANK_EN
        BLANK01: begin
          state_n = SHOW1;
          blank_n = 1'b0;
        end
        BLANK10: begin
          state_n = SHOW0;
          blank_n = 1'b0;
          tick_n  = 1'b1;
        end
`endif
        default: begin
          state_n = IDLE;
          sel_n   = SEL_DIGIT0;
          hex_n   = HEX_IDLE;
          blank_n = 1'b1;
        end
      endcase
    end
  end

endmodule
